// File: rtl/fir_mon_pkg.sv
// Shared definitions for the FIR latency monitor: marker codes, FSM encoding and
// a width-generic saturating adder.
package fir_mon_pkg;

    localparam logic [15:0] START_CODE_DEF = 16'h00A5;
    localparam logic [7:0]  END_CODE_DEF   = 8'h5A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_e;

    // Returns {clipped, value}; value is clamped to the largest w-bit unsigned number.
    function automatic logic [64:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] max_val;
        logic [64:0] sum;
        max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum     = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return {1'b1, max_val};
        end
        return sum;
    endfunction

endpackage

// File: rtl/fir_latency_monitor.sv
// Measures FIR firmware latency from the user status word: START marker opens a run,
// END low byte closes it; per-run cycles/Y are buffered and summed with saturation.
module fir_latency_monitor
    import fir_mon_pkg::*;
#(
    parameter int          NUM_RUNS   = 3,
    parameter int          CYC_W      = 32,
    parameter logic [15:0] START_CODE = START_CODE_DEF,
    parameter logic [7:0]  END_CODE   = END_CODE_DEF,
    parameter int          IDX_W      = $clog2(NUM_RUNS + 1)
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             clear,
    input  logic [15:0]      checkbits,
    output logic             busy,
    output logic             run_done,
    output logic [IDX_W-1:0] run_idx,
    output logic [CYC_W-1:0] last_cycles,
    output logic [7:0]       last_y,
    output logic             all_done,
    output logic [CYC_W-1:0] total_cycles,
    output logic             overflow,
    input  logic [IDX_W-1:0] rd_sel,
    output logic [CYC_W-1:0] rd_cycles,
    output logic [7:0]       rd_y
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RUNS - 1);

    mon_state_e       state;
    mon_state_e       state_nxt;
    logic [15:0]      chk_q;
    logic [CYC_W-1:0] cnt;
    logic [CYC_W-1:0] res_cycles [NUM_RUNS];
    logic [7:0]       res_y      [NUM_RUNS];
    logic             start_hit;
    logic             end_hit;
    logic [64:0]      cnt_inc;
    logic [64:0]      tot_inc;

    assign start_hit = (chk_q == START_CODE);
    assign end_hit   = (chk_q[7:0] == END_CODE);
    assign cnt_inc   = sat_add(64'(cnt), 64'd1, CYC_W);
    assign tot_inc   = sat_add(64'(total_cycles), 64'(cnt), CYC_W);

    assign busy     = (state == ST_RUN);
    assign all_done = (state == ST_DONE);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear outranks every transition, so an in-flight run is simply abandoned
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_hit) state_nxt = ST_RUN;
                ST_RUN:  if (end_hit) state_nxt = (run_idx == LAST_IDX) ? ST_DONE : ST_IDLE;
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            chk_q        <= '0;
            cnt          <= '0;
            run_done     <= 1'b0;
            run_idx      <= '0;
            last_cycles  <= '0;
            last_y       <= '0;
            total_cycles <= '0;
            overflow     <= 1'b0;
            for (int i = 0; i < NUM_RUNS; i++) begin
                res_cycles[i] <= '0;
                res_y[i]      <= '0;
            end
        end else begin
            chk_q    <= checkbits;
            run_done <= 1'b0;
            if (clear) begin
                cnt          <= '0;
                run_idx      <= '0;
                last_cycles  <= '0;
                last_y       <= '0;
                total_cycles <= '0;
                overflow     <= 1'b0;
                for (int i = 0; i < NUM_RUNS; i++) begin
                    res_cycles[i] <= '0;
                    res_y[i]      <= '0;
                end
            end else if (state == ST_IDLE) begin
                if (start_hit) cnt <= CYC_W'(1);
            end else if (state == ST_RUN) begin
                if (!end_hit) begin
                    cnt <= CYC_W'(cnt_inc);
                    if (cnt_inc[64]) overflow <= 1'b1;
                end else begin
                    for (int i = 0; i < NUM_RUNS; i++) begin
                        if (run_idx == IDX_W'(i)) begin
                            res_cycles[i] <= cnt;
                            res_y[i]      <= chk_q[15:8];
                        end
                    end
                    last_cycles  <= cnt;
                    last_y       <= chk_q[15:8];
                    total_cycles <= CYC_W'(tot_inc);
                    if (tot_inc[64]) overflow <= 1'b1;
                    run_idx      <= run_idx + IDX_W'(1);
                    run_done     <= 1'b1;
                end
            end
        end
    end

    // Indices at or beyond NUM_RUNS fall through to zero
    always_comb begin
        rd_cycles = '0;
        rd_y      = '0;
        for (int i = 0; i < NUM_RUNS; i++) begin
            if (rd_sel == IDX_W'(i)) begin
                rd_cycles = res_cycles[i];
                rd_y      = res_y[i];
            end
        end
    end

endmodule

// File: tb/tb_fir_latency_monitor.sv
// Bench for fir_latency_monitor: directed scenarios plus random status-word traffic,
// checked every cycle against an edge-index reference model (32-bit and 4-bit counters).
module tb_fir_latency_monitor;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]       mode;
        logic [15:0]      prev;
        logic [31:0]      ecount;
        logic [31:0]      start_n;
        logic [1:0]       idx;
        logic [31:0]      last_c;
        logic [7:0]       last_y;
        logic [31:0]      total;
        logic             ovf;
        logic             done_pulse;
        logic [2:0][31:0] rc;
        logic [2:0][7:0]  ry;
    } mdl_t;

    logic        clk = 1'b0;
    logic        resetb = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] checkbits = '0;
    logic [1:0]  rd_sel = '0;

    logic        busy_w, run_done_w, all_done_w, ovf_w;
    logic [1:0]  run_idx_w;
    logic [31:0] last_cycles_w, total_w, rdc_w;
    logic [7:0]  last_y_w, rdy_w;

    logic        busy_s, run_done_s, all_done_s, ovf_s;
    logic [1:0]  run_idx_s;
    logic [3:0]  last_cycles_s, total_s, rdc_s;
    logic [7:0]  last_y_s, rdy_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    mdl_t m_w;
    mdl_t m_s;

    always #5 clk = ~clk;

    fir_latency_monitor dut_w (
        .clock(clk), .resetb(resetb), .clear(clear), .checkbits(checkbits),
        .busy(busy_w), .run_done(run_done_w), .run_idx(run_idx_w),
        .last_cycles(last_cycles_w), .last_y(last_y_w), .all_done(all_done_w),
        .total_cycles(total_w), .overflow(ovf_w), .rd_sel(rd_sel),
        .rd_cycles(rdc_w), .rd_y(rdy_w)
    );

    fir_latency_monitor #(.CYC_W(4)) dut_s (
        .clock(clk), .resetb(resetb), .clear(clear), .checkbits(checkbits),
        .busy(busy_s), .run_done(run_done_s), .run_idx(run_idx_s),
        .last_cycles(last_cycles_s), .last_y(last_y_s), .all_done(all_done_s),
        .total_cycles(total_s), .overflow(ovf_s), .rd_sel(rd_sel),
        .rd_cycles(rdc_s), .rd_y(rdy_s)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the specification: runs are measured as the distance between the
    // edge that loaded START and the edge that loaded END, clipped to the counter range.
    function automatic mdl_t model_step(input mdl_t mi, input logic [15:0] word,
                                        input logic clr, input int w);
        mdl_t        m;
        logic [63:0] mx, len, t;
        m  = mi;
        mx = (w >= 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
        m.ecount     = m.ecount + 32'd1;
        m.done_pulse = 1'b0;
        if (clr) begin
            m.mode   = M_IDLE;
            m.idx    = '0;
            m.last_c = '0;
            m.last_y = '0;
            m.total  = '0;
            m.ovf    = 1'b0;
            m.rc     = '0;
            m.ry     = '0;
        end else if (m.mode == M_IDLE) begin
            if (m.prev == 16'h00A5) begin
                m.mode    = M_RUN;
                m.start_n = m.ecount - 32'd1;
            end
        end else if (m.mode == M_RUN) begin
            len = 64'(m.ecount) - 64'd1 - 64'(m.start_n);
            if (m.prev[7:0] == 8'h5A) begin
                if (len > mx) begin
                    len   = mx;
                    m.ovf = 1'b1;
                end
                t = 64'(m.total) + len;
                if (t > mx) begin
                    t     = mx;
                    m.ovf = 1'b1;
                end
                m.rc[m.idx]  = len[31:0];
                m.ry[m.idx]  = m.prev[15:8];
                m.last_c     = len[31:0];
                m.last_y     = m.prev[15:8];
                m.total      = t[31:0];
                m.idx        = m.idx + 2'd1;
                m.done_pulse = 1'b1;
                m.mode       = (m.idx == 2'd3) ? M_DONE : M_IDLE;
            end else if (len + 64'd1 > mx) begin
                m.ovf = 1'b1;
            end
        end
        m.prev = word;
        return m;
    endfunction

    task automatic compare_all(input string p, input mdl_t m,
                               input logic o_busy, input logic o_rdone, input logic [1:0] o_idx,
                               input logic [63:0] o_lc, input logic [7:0] o_ly, input logic o_ad,
                               input logic [63:0] o_tot, input logic o_ovf,
                               input logic [63:0] o_rdc, input logic [7:0] o_rdy);
        logic [31:0] e_rdc;
        logic [7:0]  e_rdy;
        e_rdc = '0;
        e_rdy = '0;
        if (rd_sel < 2'd3) begin
            e_rdc = m.rc[rd_sel];
            e_rdy = m.ry[rd_sel];
        end
        check_val({p, ".busy"},        64'(o_busy),  64'(m.mode == M_RUN));
        check_val({p, ".all_done"},    64'(o_ad),    64'(m.mode == M_DONE));
        check_val({p, ".run_done"},    64'(o_rdone), 64'(m.done_pulse));
        check_val({p, ".run_idx"},     64'(o_idx),   64'(m.idx));
        check_val({p, ".last_cycles"}, o_lc,         64'(m.last_c));
        check_val({p, ".last_y"},      64'(o_ly),    64'(m.last_y));
        check_val({p, ".total"},       o_tot,        64'(m.total));
        check_val({p, ".overflow"},    64'(o_ovf),   64'(m.ovf));
        check_val({p, ".rd_cycles"},   o_rdc,        64'(e_rdc));
        check_val({p, ".rd_y"},        64'(o_rdy),   64'(e_rdy));
    endtask

    task automatic compare_both();
        compare_all("w", m_w, busy_w, run_done_w, run_idx_w, 64'(last_cycles_w), last_y_w,
                    all_done_w, 64'(total_w), ovf_w, 64'(rdc_w), rdy_w);
        compare_all("s", m_s, busy_s, run_done_s, run_idx_s, 64'(last_cycles_s), last_y_s,
                    all_done_s, 64'(total_s), ovf_s, 64'(rdc_s), rdy_s);
    endtask

    task automatic step(input logic [15:0] word, input logic clr);
        checkbits = word;
        clear     = clr;
        @(posedge clk);
        m_w = model_step(m_w, word, clr, 32);
        m_s = model_step(m_s, word, clr, 4);
        #1;
        compare_both();
    endtask

    task automatic run_seq(input int len, input logic [7:0] y);
        repeat (len) step(16'h00A5, 1'b0);
        step({y, 8'h5A}, 1'b0);
        step(16'h0000, 1'b0);
    endtask

    task automatic do_reset();
        #2 resetb = 1'b0;
        #1;
        m_w = '0;
        m_s = '0;
        compare_both();
        repeat (2) @(posedge clk);
        #1;
        compare_both();
        #2 resetb = 1'b1;
        #1;
    endtask

    task automatic check_buffer(input string p, input logic [31:0] c0, input logic [31:0] c1,
                                input logic [31:0] c2, input logic [7:0] y0,
                                input logic [7:0] y1, input logic [7:0] y2);
        logic [2:0][31:0] ec;
        logic [2:0][7:0]  ey;
        ec = {c2, c1, c0};
        ey = {y2, y1, y0};
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check_val($sformatf("%s.rd_cycles[%0d]", p, i), 64'(rdc_w), (i < 3) ? 64'(ec[i]) : 64'd0);
            check_val($sformatf("%s.rd_y[%0d]", p, i), 64'(rdy_w), (i < 3) ? 64'(ey[i]) : 64'd0);
        end
        rd_sel = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic        clr;
        int          r;
        m_w = '0;
        m_s = '0;
        do_reset();

        // single run of 10 cycles
        run_seq(10, 8'h2A);
        check_val("t1.run_done", 64'(run_done_w), 64'd1);
        check_val("t1.last_cycles", 64'(last_cycles_w), 64'd10);
        check_val("t1.last_y", 64'(last_y_w), 64'h2A);
        check_val("t1.run_idx", 64'(run_idx_w), 64'd1);
        step(16'h0000, 1'b0);
        check_val("t1.run_done_gone", 64'(run_done_w), 64'd0);

        // three runs fill the buffer, a fourth is ignored
        step(16'h0000, 1'b1);
        run_seq(10, 8'h11);
        run_seq(250, 8'h22);
        run_seq(1, 8'h33);
        check_val("t2.total", 64'(total_w), 64'd261);
        check_val("t2.all_done", 64'(all_done_w), 64'd1);
        check_val("t2.run_idx", 64'(run_idx_w), 64'd3);
        check_val("t2.small_total", 64'(total_s), 64'd15);
        check_buffer("t2", 32'd10, 32'd250, 32'd1, 8'h11, 8'h22, 8'h33);
        run_seq(5, 8'h44);
        check_val("t2.total_after", 64'(total_w), 64'd261);
        check_val("t2.last_y_after", 64'(last_y_w), 64'h33);
        check_val("t2.run_done_after", 64'(run_done_w), 64'd0);
        check_buffer("t2b", 32'd10, 32'd250, 32'd1, 8'h11, 8'h22, 8'h33);

        // END while idle is ignored; START re-sent mid-run is counted
        step(16'h0000, 1'b1);
        repeat (3) step(16'h005A, 1'b0);
        step(16'h0000, 1'b0);
        check_val("t3.idle_end_idx", 64'(run_idx_w), 64'd0);
        repeat (4) step(16'h00A5, 1'b0);
        repeat (2) step(16'h1234, 1'b0);
        repeat (3) step(16'h00A5, 1'b0);
        step(16'h775A, 1'b0);
        step(16'h0000, 1'b0);
        check_val("t3.last_cycles", 64'(last_cycles_w), 64'd9);
        check_val("t3.last_y", 64'(last_y_w), 64'h77);

        // 4-bit counters saturate on a 20-cycle run
        step(16'h0000, 1'b1);
        run_seq(20, 8'h01);
        check_val("t4.small_last", 64'(last_cycles_s), 64'd15);
        check_val("t4.small_ovf", 64'(ovf_s), 64'd1);
        check_val("t4.small_total", 64'(total_s), 64'd15);
        check_val("t4.wide_last", 64'(last_cycles_w), 64'd20);
        check_val("t4.wide_ovf", 64'(ovf_w), 64'd0);

        // clear in the middle of a run
        repeat (5) step(16'h00A5, 1'b0);
        check_val("t5.busy_before", 64'(busy_w), 64'd1);
        step(16'h0000, 1'b1);
        check_val("t5.busy", 64'(busy_w), 64'd0);
        check_val("t5.run_done", 64'(run_done_w), 64'd0);
        check_val("t5.run_idx", 64'(run_idx_w), 64'd0);
        check_val("t5.small_ovf", 64'(ovf_s), 64'd0);
        check_buffer("t5", 32'd0, 32'd0, 32'd0, 8'h00, 8'h00, 8'h00);
        step(16'h105A, 1'b0);
        step(16'h0000, 1'b0);
        check_val("t5.no_capture", 64'(run_idx_w), 64'd0);

        // async reset in the middle of a run, then a fresh run
        repeat (4) step(16'h00A5, 1'b0);
        check_val("t6.busy_before", 64'(busy_w), 64'd1);
        do_reset();
        check_val("t6.busy_reset", 64'(busy_w), 64'd0);
        run_seq(7, 8'h6B);
        check_val("t6.last_cycles", 64'(last_cycles_w), 64'd7);
        check_val("t6.run_idx", 64'(run_idx_w), 64'd1);
        check_val("t6.last_y", 64'(last_y_w), 64'h6B);

        // random traffic
        for (int i = 0; i < 700; i++) begin
            r      = int'($urandom_range(99));
            rd_sel = 2'($urandom_range(3));
            clr    = 1'b0;
            if (r < 45)      w = 16'h00A5;
            else if (r < 58) w = {8'($urandom), 8'h5A};
            else if (r < 61) begin
                w   = 16'($urandom);
                clr = 1'b1;
            end else         w = 16'($urandom);
            step(w, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
